// File: rtl/fifo_drain_if.sv
// fifo_drain_if: store read port plus output valid/ready stream of the drain stage
// master: drain controller side (drives src_rd, m_valid, m_data)
// slave:  store/consumer side (drives src_empty, src_data, m_ready)
interface fifo_drain_if #(
  parameter int DATA_W = 8
);
  logic              src_empty;
  logic              src_rd;
  logic [DATA_W-1:0] src_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  modport master (input src_empty, src_data, m_ready, output src_rd, m_valid, m_data);
  modport slave (output src_empty, src_data, m_ready, input src_rd, m_valid, m_data);
endinterface

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: credit-controlled read drain from a byte store into a valid/ready stream
// clk, rst_n (async, active-low), en (drain enable), busy (state != IDLE)
// bus: src_empty/src_data in, src_rd out; m_valid/m_data out, m_ready in
// DRAIN_CNT_EN: adds drain_cnt[15:0], a saturating count of output handshakes
module fifo_drain_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic busy,
`ifdef DRAIN_CNT_EN
  fifo_drain_if.master bus,
  output logic [15:0] drain_cnt
`else
  fifo_drain_if.master bus
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t            state, state_nx;
  logic [RD_LAT-1:0] pipe;
  logic [IW-1:0]     inflight;
  logic [CW:0]       used;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push, pop;
  assign push = pipe[RD_LAT-1];
  assign pop = bus.m_valid && bus.m_ready;
  assign bus.m_valid = count != '0;
  assign bus.m_data = mem[rd_ptr];
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(pipe[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (en ? RUN : IDLE) :
               state == RUN  ? (en ? RUN : STOP) :
               en ? RUN : (inflight == '0 ? IDLE : STOP);
  // credits: reads already in flight own a buffer slot, so full never overflows
  always_comb begin
    used = (CW+1)'(inflight) + (CW+1)'(count);
    busy = state != IDLE;
    bus.src_rd = state == RUN && !bus.src_empty && used < (CW+1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pipe   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pipe <= RD_LAT'({pipe, bus.src_rd});
      if (push) begin
        mem[wr_ptr] <= bus.src_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (rst_n) assert (!(push && count == CW'(DEPTH)));
`ifdef DRAIN_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drain_cnt <= '0;
    else if (pop && drain_cnt != 16'hFFFF) drain_cnt <= drain_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed bench for fifo_drain_ctrl with RD_LAT=1 and RD_LAT=3 instances
module tb_fifo_drain_ctrl;
  logic clk, rst_n, en1, en3, busy1, busy3;
  int   checks, errors;
  fifo_drain_if #(.DATA_W(8)) if1 ();
  fifo_drain_if #(.DATA_W(8)) if3 ();
`ifdef DRAIN_CNT_EN
  logic [15:0] cnt1, cnt3;
`endif
  fifo_drain_ctrl #(.DATA_W(8), .DEPTH(4), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .busy(busy1),
`ifdef DRAIN_CNT_EN
    .bus(if1), .drain_cnt(cnt1)
`else
    .bus(if1)
`endif
  );
  fifo_drain_ctrl #(.DATA_W(8), .DEPTH(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .busy(busy3),
`ifdef DRAIN_CNT_EN
    .bus(if3), .drain_cnt(cnt3)
`else
    .bus(if3)
`endif
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // byte store models: entry i holds base+i, head advances on rd, data appears RD_LAT edges later
  int h1, t1, h3, t3;
  logic [7:0] b1, b3, d1;
  logic [7:0] d3 [3];
  logic c1, c3;
  assign if1.src_empty = h1 >= t1;
  assign if1.src_data = d1;
  assign if3.src_empty = h3 >= t3;
  assign if3.src_data = d3[2];
  always @(posedge clk) begin
    if (c1) h1 <= 0;
    else if (if1.src_rd) begin
      h1 <= h1 + 1;
      d1 <= b1 + 8'(h1);
    end
  end
  always @(posedge clk) begin
    if (c3) h3 <= 0;
    else if (if3.src_rd) h3 <= h3 + 1;
    if (if3.src_rd) d3[0] <= b3 + 8'(h3);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  typedef struct {
    logic       en, rdy, rd, v;
    logic [7:0] d;
    logic       bsy;
  } vec_t;
  vec_t tv [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    en1 = 0;
    en3 = 0;
    if1.m_ready = 0;
    if3.m_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
  endtask
  task automatic load1(input logic [7:0] base, input int n);
    c1 = 1;
    b1 = base;
    t1 = n;
    @(negedge clk);
    c1 = 0;
    #1;
  endtask
  task automatic load3(input logic [7:0] base, input int n);
    c3 = 1;
    b3 = base;
    t3 = n;
    @(negedge clk);
    c3 = 0;
    #1;
  endtask
  task automatic drain(input bit s3, input int n, input logic [7:0] first, input int budget,
                       output int cyc);
    int got;
    got = 0;
    cyc = 0;
    if (s3) if3.m_ready = 1;
    else if1.m_ready = 1;
    while (got < n && cyc < budget) begin
      if (s3 ? if3.m_valid : if1.m_valid) begin
        chk("drain_data", s3 ? if3.m_data : if1.m_data, 8'(first + 8'(got)));
        got++;
      end
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("drain_count", got, n);
    if (s3) if3.m_ready = 0;
    else if1.m_ready = 0;
  endtask
  task automatic s3(input logic rd, input logic v, input logic bsy, input logic [7:0] d);
    chk("t3_rd", if3.src_rd, rd);
    chk("t3_valid", if3.m_valid, v);
    chk("t3_busy", busy3, bsy);
    if (v) chk("t3_data", if3.m_data, d);
    @(negedge clk);
    #1;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1);
  end
  initial begin
    int cyc, pulses;
    checks = 0;
    errors = 0;
    c1 = 0;
    c3 = 0;
    t1 = 0;
    t3 = 0;
    b1 = 0;
    b3 = 0;
    rst_n = 0;
    en1 = 0;
    en3 = 0;
    if1.m_ready = 0;
    if3.m_ready = 0;
    #12;
    chk("rst_valid", if1.m_valid, 0);
    chk("rst_data", if1.m_data, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_rd", if1.src_rd, 0);
    // 8 bytes streamed back to back with consumer always ready
    tv[0]  = '{1, 1, 0, 0, 8'h00, 0};
    tv[1]  = '{1, 1, 1, 0, 8'h00, 1};
    tv[2]  = '{1, 1, 1, 0, 8'h00, 1};
    tv[3]  = '{1, 1, 1, 1, 8'h10, 1};
    tv[4]  = '{1, 1, 1, 1, 8'h11, 1};
    tv[5]  = '{1, 1, 1, 1, 8'h12, 1};
    tv[6]  = '{1, 1, 1, 1, 8'h13, 1};
    tv[7]  = '{1, 1, 1, 1, 8'h14, 1};
    tv[8]  = '{1, 1, 1, 1, 8'h15, 1};
    tv[9]  = '{1, 1, 0, 1, 8'h16, 1};
    tv[10] = '{1, 1, 0, 1, 8'h17, 1};
    tv[11] = '{1, 1, 0, 0, 8'h00, 1};
    do_reset();
    load1(8'h10, 8);
    for (int k = 0; k < 12; k++) begin
      en1 = tv[k].en;
      if1.m_ready = tv[k].rdy;
      #1;
      chk("t1_rd", if1.src_rd, tv[k].rd);
      chk("t1_valid", if1.m_valid, tv[k].v);
      chk("t1_busy", busy1, tv[k].bsy);
      if (tv[k].v) chk("t1_data", if1.m_data, tv[k].d);
      @(negedge clk);
      #1;
    end
    // credits stop reads at 4 with a stalled consumer; release drains 10 bytes with no gap
    do_reset();
    load1(8'h10, 10);
    en1 = 1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (if1.src_rd) pulses++;
      @(negedge clk);
      #1;
    end
    chk("t2_pulses", pulses, 4);
    chk("t2_rd_stalled", if1.src_rd, 0);
    chk("t2_valid_held", if1.m_valid, 1);
    chk("t2_data_held", if1.m_data, 8'h10);
    drain(0, 10, 8'h10, 40, cyc);
    chk("t2_cycles", cyc, 10);
    // RD_LAT=3: en drops after two reads, STOP waits for both captures, then IDLE
    do_reset();
    load3(8'h50, 2);
    en3 = 1;
    s3(0, 0, 0, 8'h00);
    s3(1, 0, 1, 8'h00);
    s3(1, 0, 1, 8'h00);
    en3 = 0;
    s3(0, 0, 1, 8'h00);
    s3(0, 0, 1, 8'h00);
    s3(0, 1, 1, 8'h50);
    s3(0, 1, 1, 8'h50);
    chk("t3_idle", busy3, 0);
    drain(1, 2, 8'h50, 10, cyc);
    chk("t3_cycles", cyc, 2);
    // reset with three buffered and one in flight; nothing stale survives
    do_reset();
    load1(8'h30, 10);
    en1 = 1;
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    chk("t5_pre_valid", if1.m_valid, 1);
    chk("t5_pre_data", if1.m_data, 8'h30);
    rst_n = 0;
    #1;
    chk("t5_rst_valid", if1.m_valid, 0);
    chk("t5_rst_busy", busy1, 0);
    chk("t5_rst_rd", if1.src_rd, 0);
    chk("t5_rst_data", if1.m_data, 0);
    @(negedge clk);
    rst_n = 1;
    en1 = 0;
    if1.m_ready = 1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t5_no_stale", if1.m_valid, 0);
      @(negedge clk);
      #1;
    end
    en1 = 1;
    drain(0, 6, 8'h34, 30, cyc);
`ifdef DRAIN_CNT_EN
    do_reset();
    chk("t6_cnt_rst", cnt1, 0);
    load1(8'h00, 5);
    en1 = 1;
    drain(0, 5, 8'h00, 30, cyc);
    chk("t6_cnt5", cnt1, 5);
    load1(8'h00, 70000);
    drain(0, 65529, 8'h00, 66000, cyc);
    chk("t6_cnt_fffe", cnt1, 16'hFFFE);
    drain(0, 3, 8'(65529), 20, cyc);
    chk("t6_cnt_sat", cnt1, 16'hFFFF);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
